// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor.
// The operand is cut into Stages equal slices; slice k is summed in pipeline
// stage k with 4-bit lookahead groups, and the carry out of each slice is
// registered before the next slice consumes it. A single global advance
// signal stalls every stage together when the output is held.

// 4-bit lookahead group: all internal carries derived directly from ci.
module cla_pipe_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // bit generate/propagate and two-level carry lookahead
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
    end
endmodule

// One pipeline slice: SW/4 lookahead groups chained by group generate/propagate.
module cla_pipe_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);
    localparam int NG = SW / 4;

    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic [3:0]    g4;
    logic [3:0]    p4;

    // group generate/propagate depend only on the operands, never on carries
    always_comb begin
        gg = '0;
        gp = '0;
        g4 = '0;
        p4 = '0;
        for (int j = 0; j < NG; j++) begin
            g4    = a[4*j +: 4] & b[4*j +: 4];
            p4    = a[4*j +: 4] ^ b[4*j +: 4];
            gg[j] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
                    (p4[3] & p4[2] & p4[1] & g4[0]);
            gp[j] = &p4;
        end
    end

    // group carries resolved from group generate/propagate
    always_comb begin
        gc    = '0;
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
    end

    assign co = gc[NG];

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_pipe_cla4 u_cla4 (
            .a  (a[4*j +: 4]),
            .b  (b[4*j +: 4]),
            .ci (gc[j]),
            .s  (s[4*j +: 4])
        );
    end
endmodule

module cla_pipe #(
    parameter int Width  = 64,
    parameter int Stages = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Width-1:0] S,
    output logic             CO,
    output logic             OV,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SW = Width / Stages;

    // per-stage registers: operands (already inverted for subtract), the
    // partial sum built so far, the slice carry-out and the slot valid bit
    logic [Stages-1:0][Width-1:0] a_q, a_d;
    logic [Stages-1:0][Width-1:0] b_q, b_d;
    logic [Stages-1:0][Width-1:0] s_q, s_d;
    logic [Stages-1:0]            c_q, c_d;
    logic [Stages-1:0]            vld_q, vld_d;
    logic                         ov_q, ov_d;

    // what each stage sees at its input
    logic [Stages-1:0][Width-1:0] a_in, b_in, s_in;
    logic [Stages-1:0]            c_in, v_in;
    logic [Stages-1:0][SW-1:0]    slc_sum;
    logic [Stages-1:0]            slc_co;
    logic                         advance;
    logic                         unused_bits;

    assign advance = !vld_q[Stages-1] || out_ready;

    // stage 0 takes the ports (B inverted and carry forced on subtract);
    // later stages take the previous stage's registers
    always_comb begin
        a_in    = '0;
        b_in    = '0;
        s_in    = '0;
        c_in    = '0;
        v_in    = '0;
        a_in[0] = A;
        b_in[0] = SUB ? ~B : B;
        c_in[0] = SUB ? 1'b1 : CI;
        v_in[0] = in_valid;
        for (int k = 1; k < Stages; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        cla_pipe_slice #(.SW(SW)) u_slice (
            .a  (a_in[k][k*SW +: SW]),
            .b  (b_in[k][k*SW +: SW]),
            .ci (c_in[k]),
            .s  (slc_sum[k]),
            .co (slc_co[k])
        );
    end

    // next state: every stage loads together on advance, otherwise holds
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        vld_d = vld_q;
        ov_d  = ov_q;
        if (advance) begin
            for (int k = 0; k < Stages; k++) begin
                a_d[k]              = a_in[k];
                b_d[k]              = b_in[k];
                s_d[k]              = s_in[k];
                s_d[k][k*SW +: SW]  = slc_sum[k];
                c_d[k]              = slc_co[k];
                vld_d[k]            = v_in[k];
            end
            // overflow needs the final sum MSB, so it is formed in the last stage
            ov_d = (a_in[Stages-1][Width-1] == b_in[Stages-1][Width-1]) &&
                   (slc_sum[Stages-1][SW-1] != a_in[Stages-1][Width-1]);
        end
    end

    // stage registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            vld_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            vld_q <= vld_d;
            ov_q  <= ov_d;
        end
    end

    // operand bits below the current slice are dead once summed; synthesis prunes them
    assign unused_bits = ^{a_q, b_q};

    assign S         = s_q[Stages-1];
    assign CO        = c_q[Stages-1];
    assign OV        = ov_q;
    assign out_valid = vld_q[Stages-1];
    assign in_ready  = advance;
endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 SHALL have parameter Width, default 64: operand/sum width; a multiple of 4, at least 4.
REQ-002 SHALL have parameter Stages, default 4: pipeline depth; 1..Width/4, and SHALL divide Width/4 exactly.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port A, input, Width: operand A.
REQ-006 SHALL have port B, input, Width: operand B.
REQ-007 SHALL have port CI, input, 1: carry-in; used only when SUB=0.
REQ-008 SHALL have port SUB, input, 1: 0 = add, 1 = subtract.
REQ-009 SHALL have port in_valid, input, 1: A/B/CI/SUB valid this cycle.
REQ-010 SHALL have port in_ready, output, 1: block accepts an operation this cycle.
REQ-011 SHALL have port S, output, Width: result, valid when out_valid=1.
REQ-012 SHALL have port CO, output, 1: carry-out of bit Width-1.
REQ-013 SHALL have port OV, output, 1: two's-complement signed overflow.
REQ-014 SHALL have port out_valid, output, 1: S/CO/OV hold a result.
REQ-015 SHALL have port out_ready, input, 1: downstream consumes the result this cycle.

Function
REQ-016 SHALL compute S,CO = A + B + CI when SUB=0, and S,CO = A + ~B + 1 when SUB=1 (CI ignored); CO=1 on SUB means no borrow.
REQ-017 SHALL compute OV = (A[W-1] == B'[W-1]) && (S[W-1] != A[W-1]), where B' is the operand actually added (B or ~B).
REQ-018 SHALL split the datapath into Stages slices of Width/Stages bits each; slice k SHALL be evaluated in pipeline stage k using 4-bit lookahead groups.
REQ-019 SHALL register the inter-slice carry between stages; no carry SHALL ripple combinationally across a stage register.
REQ-020 SHALL carry each operand's unused upper slices, and the completed lower sum slices, forward in stage registers alongside a per-stage valid bit.
REQ-021 SHALL define advance = !out_valid || out_ready; all stage registers SHALL load only when advance=1 (global stall).
REQ-022 SHALL drive in_ready = advance; a transfer occurs on in_valid && in_ready.
REQ-023 SHALL load stage-0 valid with in_valid on advance, so bubbles propagate as invalid slots.
REQ-024 SHALL produce a result exactly Stages cycles after acceptance when no stall occurs; throughput SHALL be one operation per cycle.
REQ-025 SHALL hold S, CO, OV and out_valid stable while out_valid=1 && out_ready=0.
REQ-026 SHALL accept a new input in the same cycle the last stage is consumed (out_valid && out_ready && in_valid).
REQ-027 SHALL preserve result order; no operation SHALL be dropped or duplicated under any out_ready pattern.
REQ-028 SHALL wrap modulo 2^Width: S is the low Width bits and CO is bit Width.
REQ-029 When Stages=1, SHALL reduce to one registered full-width lookahead stage with latency 1.

Reset
REQ-030 SHALL, while rst=1, asynchronously clear every stage valid bit, out_valid, S, CO and OV to 0.
REQ-031 SHALL discard all in-flight operations on rst assertion mid-operation; the first accepted input after release SHALL emerge Stages cycles later.
REQ-032 SHALL hold in_ready=1 during and immediately after reset, since out_valid=0.

Verification (Width=16, Stages=4)
REQ-033 SHALL cover add: A=0x1234, B=0x0FF1, CI=1, SUB=0 -> exactly 4 cycles later S=0x2226, CO=0, OV=0.
REQ-034 SHALL cover wrap: A=0xFFFF, B=0x0000, CI=1, SUB=0 -> S=0x0000, CO=1, OV=0; and A=0x7FFF, B=0x0001, CI=0 -> S=0x8000, CO=0, OV=1.
REQ-035 SHALL cover subtract: A=0x0005, B=0x0005, SUB=1 -> S=0x0000, CO=1; and A=0x0003, B=0x0005, SUB=1 -> S=0xFFFE, CO=0, OV=0.
REQ-036 SHALL cover backpressure: stream 8 back-to-back ops with out_ready=0 for cycles 5-9 -> in_ready=0 during those cycles, outputs held stable, all 8 results emerge in order.
REQ-037 SHALL cover mid-flight reset: assert rst with 3 ops in flight -> out_valid=0 and S=0 immediately; after release, no stale result appears.
REQ-038 SHALL cover random streams: random A/B/CI/SUB, random in_valid and out_ready -> every result matches a reference sum, ordering and OV included.
